// File: rtl/ttt_turn_ctrl.sv
// ttt_turn_ctrl: tic-tac-toe turn sequencer, sole writer of the 3x3 board.
// Optional per-turn forfeit timer enabled by defining TURN_TIMEOUT_EN.
module ttt_turn_ctrl #(
  parameter bit          P1_FIRST       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        key_valid,
  input  logic [3:0]  key_data,
  output logic [17:0] board,
  output logic        is_turn_o,
  output logic        move_ok,
  output logic        move_err,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic FIRST_TURN = ~P1_FIRST;

  localparam logic [1:0] MARK_P1 = 2'b01;
  localparam logic [1:0] MARK_P2 = 2'b10;

  logic [1:0] state;
  logic       key_valid_q;
  logic       press;
  logic [8:0] sel;
  logic [8:0] busy;
  logic [8:0] p1_cells;
  logic [8:0] p2_cells;
  logic       cell_free;
  logic       move_acc;
  logic       move_rej;
  logic [1:0] mark;
  logic       p1_line;
  logic       p2_line;
  logic       full;
  logic       to_fire;

  // True when any of the 8 winning lines is fully owned.
  function automatic logic has_line(input logic [8:0] c);
    logic r;
    r = (c[0] & c[1] & c[2]) |
        (c[3] & c[4] & c[5]) |
        (c[6] & c[7] & c[8]) |
        (c[0] & c[3] & c[6]) |
        (c[1] & c[4] & c[7]) |
        (c[2] & c[5] & c[8]) |
        (c[0] & c[4] & c[8]) |
        (c[2] & c[4] & c[6]);
    return r;
  endfunction

  assign press = key_valid & ~key_valid_q;
  assign mark  = is_turn_o ? MARK_P2 : MARK_P1;

  // Per-cell decode: key selection and occupancy by owner.
  always_comb begin
    sel      = '0;
    busy     = '0;
    p1_cells = '0;
    p2_cells = '0;
    for (int k = 0; k < 9; k++) begin
      sel[k]      = (key_data == 4'(k + 1));
      busy[k]     = |board[2*k +: 2];
      p1_cells[k] = (board[2*k +: 2] == MARK_P1);
      p2_cells[k] = (board[2*k +: 2] == MARK_P2);
    end
  end

  // Invalid codes select no cell, so they never count as free.
  assign cell_free = |(sel & ~busy);
  assign move_acc  = (state == S_WAIT) & press & cell_free;
  assign move_rej  = (state == S_WAIT) & press & ~cell_free;

  assign p1_line = has_line(p1_cells);
  assign p2_line = has_line(p2_cells);
  assign full    = &busy;

  assign game_over = (state == S_DONE);

`ifdef TURN_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] turn_cnt;

  // Any press at expiry suppresses the forfeit.
  assign to_fire = (state == S_WAIT) & ~press & (turn_cnt == LAST);

  // Turn timer: runs only while waiting for a key, held at the
  // last value if a rejected press lands exactly on expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      turn_cnt <= '0;
    end else if (state != S_WAIT || move_acc || to_fire) begin
      turn_cnt <= '0;
    end else if (turn_cnt != LAST) begin
      turn_cnt <= turn_cnt + 1'b1;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign to_fire = 1'b0;
`endif

  // Main sequencer: board writes, turn order, result and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      board       <= '0;
      is_turn_o   <= FIRST_TURN;
      move_ok     <= 1'b0;
      move_err    <= 1'b0;
      timeout     <= 1'b0;
      winner      <= 2'b00;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= key_valid;
      move_ok     <= 1'b0;
      move_err    <= 1'b0;
      timeout     <= to_fire;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_WAIT;
            board     <= '0;
            winner    <= 2'b00;
            is_turn_o <= FIRST_TURN;
          end
        end
        S_WAIT: begin
          if (move_acc) begin
            for (int k = 0; k < 9; k++) begin
              if (sel[k]) begin
                board[2*k +: 2] <= mark;
              end
            end
            move_ok <= 1'b1;
            state   <= S_CHECK;
          end else if (move_rej) begin
            move_err <= 1'b1;
          end else if (to_fire) begin
            is_turn_o <= ~is_turn_o;
          end
        end
        S_CHECK: begin
          if (p1_line) begin
            winner <= MARK_P1;
            state  <= S_DONE;
          end else if (p2_line) begin
            winner <= MARK_P2;
            state  <= S_DONE;
          end else if (full) begin
            winner <= 2'b00;
            state  <= S_DONE;
          end else begin
            is_turn_o <= ~is_turn_o;
            state     <= S_WAIT;
          end
        end
        S_DONE: begin
          if (start) begin
            state     <= S_WAIT;
            board     <= '0;
            winner    <= 2'b00;
            is_turn_o <= FIRST_TURN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// tb_ttt_turn_ctrl: directed vector bench for ttt_turn_ctrl.
// Define TURN_TIMEOUT_EN to exercise the forfeit timer.
module tb_ttt_turn_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        key_valid;
  logic [3:0]  key_data;
  logic [17:0] board;
  logic        is_turn_o;
  logic        move_ok;
  logic        move_err;
  logic        game_over;
  logic [1:0]  winner;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ttt_turn_ctrl #(
    .P1_FIRST      (1'b1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_valid(key_valid),
    .key_data (key_data),
    .board    (board),
    .is_turn_o(is_turn_o),
    .move_ok  (move_ok),
    .move_err (move_err),
    .game_over(game_over),
    .winner   (winner),
    .timeout  (timeout)
  );

  typedef struct {
    logic        st;
    logic [3:0]  key;
    logic        ok;
    logic        err;
    logic [17:0] brd;
    logic        turn;
    logic        over;
    logic [1:0]  win;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic [3:0] key, logic ok,
                              logic err, logic [17:0] brd, logic turn,
                              logic over, logic [1:0] win);
    vec_t v;
    v.st = st; v.key = key; v.ok = ok; v.err = err;
    v.brd = brd; v.turn = turn; v.over = over; v.win = win;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int pulses;

    // game 1: P1 takes row 0
    vecs.push_back(mk(1, 0, 0, 0, 18'h00000, 0, 0, 2'b00));
    vecs.push_back(mk(0, 1, 1, 0, 18'h00001, 1, 0, 2'b00));
    vecs.push_back(mk(0, 4, 1, 0, 18'h00081, 0, 0, 2'b00));
    vecs.push_back(mk(0, 2, 1, 0, 18'h00085, 1, 0, 2'b00));
    vecs.push_back(mk(0, 5, 1, 0, 18'h00285, 0, 0, 2'b00));
    vecs.push_back(mk(0, 3, 1, 0, 18'h00295, 0, 1, 2'b01));
    vecs.push_back(mk(0, 1, 0, 0, 18'h00295, 0, 1, 2'b01));
    // game 2: draw
    vecs.push_back(mk(1, 0, 0, 0, 18'h00000, 0, 0, 2'b00));
    vecs.push_back(mk(0, 1, 1, 0, 18'h00001, 1, 0, 2'b00));
    vecs.push_back(mk(0, 2, 1, 0, 18'h00009, 0, 0, 2'b00));
    vecs.push_back(mk(0, 3, 1, 0, 18'h00019, 1, 0, 2'b00));
    vecs.push_back(mk(0, 5, 1, 0, 18'h00219, 0, 0, 2'b00));
    vecs.push_back(mk(0, 4, 1, 0, 18'h00259, 1, 0, 2'b00));
    vecs.push_back(mk(0, 6, 1, 0, 18'h00A59, 0, 0, 2'b00));
    vecs.push_back(mk(0, 8, 1, 0, 18'h04A59, 1, 0, 2'b00));
    vecs.push_back(mk(0, 7, 1, 0, 18'h06A59, 0, 0, 2'b00));
    vecs.push_back(mk(0, 9, 1, 0, 18'h16A59, 0, 1, 2'b00));
    // game 3: P1 wins on the ninth move
    vecs.push_back(mk(1, 0, 0, 0, 18'h00000, 0, 0, 2'b00));
    vecs.push_back(mk(0, 1, 1, 0, 18'h00001, 1, 0, 2'b00));
    vecs.push_back(mk(0, 2, 1, 0, 18'h00009, 0, 0, 2'b00));
    vecs.push_back(mk(0, 3, 1, 0, 18'h00019, 1, 0, 2'b00));
    vecs.push_back(mk(0, 4, 1, 0, 18'h00099, 0, 0, 2'b00));
    vecs.push_back(mk(0, 5, 1, 0, 18'h00199, 1, 0, 2'b00));
    vecs.push_back(mk(0, 7, 1, 0, 18'h02199, 0, 0, 2'b00));
    vecs.push_back(mk(0, 8, 1, 0, 18'h06199, 1, 0, 2'b00));
    vecs.push_back(mk(0, 6, 1, 0, 18'h06999, 0, 0, 2'b00));
    vecs.push_back(mk(0, 9, 1, 0, 18'h16999, 0, 1, 2'b01));
    // game 4: rejected presses, start ignored mid-game
    vecs.push_back(mk(1, 0, 0, 0, 18'h00000, 0, 0, 2'b00));
    vecs.push_back(mk(0, 5, 1, 0, 18'h00100, 1, 0, 2'b00));
    vecs.push_back(mk(0, 5, 0, 1, 18'h00100, 1, 0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 1, 18'h00100, 1, 0, 2'b00));
    vecs.push_back(mk(0, 12, 0, 1, 18'h00100, 1, 0, 2'b00));
    vecs.push_back(mk(0, 9, 1, 0, 18'h20100, 0, 0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 0, 18'h20100, 0, 0, 2'b00));

    rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_data = 4'd0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst board", 32'(board), 0);
    chk("rst turn", 32'(is_turn_o), 0);
    chk("rst over", 32'(game_over), 0);
    chk("rst winner", 32'(winner), 0);
    chk("rst pulses", {29'd0, move_ok, move_err, timeout}, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].st) begin
        start = 1'b1;
        step();
        start = 1'b0;
      end else begin
        key_valid = 1'b1;
        key_data  = vecs[i].key;
        step();
      end
      chk($sformatf("v%0d move_ok", i), 32'(move_ok), 32'(vecs[i].ok));
      chk($sformatf("v%0d move_err", i), 32'(move_err), 32'(vecs[i].err));
      chk($sformatf("v%0d board", i), 32'(board), 32'(vecs[i].brd));
      key_valid = 1'b0;
      step();
      chk($sformatf("v%0d turn", i), 32'(is_turn_o), 32'(vecs[i].turn));
      chk($sformatf("v%0d over", i), 32'(game_over), 32'(vecs[i].over));
      chk($sformatf("v%0d winner", i), 32'(winner), 32'(vecs[i].win));
      chk($sformatf("v%0d pulse clr", i), {30'd0, move_ok, move_err}, 0);
    end

    // held key: one move only
    key_valid = 1'b1;
    key_data  = 4'd1;
    step();
    chk("hold first ok", 32'(move_ok), 1);
    step();
    chk("hold turn", 32'(is_turn_o), 1);
    pulses = 0;
    repeat (98) begin
      step();
      if (move_ok || move_err) pulses++;
    end
    chk("hold repeats", 32'(pulses), 0);
    key_valid = 1'b0;
    step();
    chk("hold board", 32'(board), 32'h20101);

    // reset while in CHECK
    key_valid = 1'b1;
    key_data  = 4'd2;
    step();
    chk("mid ok", 32'(move_ok), 1);
    chk("mid board", 32'(board), 32'h20109);
    rst = 1'b1;
    key_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("mid rst board", 32'(board), 0);
    chk("mid rst turn", 32'(is_turn_o), 0);
    chk("mid rst over", 32'(game_over), 0);
    chk("mid rst winner", 32'(winner), 0);
    chk("mid rst pulses", {29'd0, move_ok, move_err, timeout}, 0);
    step();
    chk("mid rst settled", {12'd0, board, is_turn_o, game_over}, 0);

    // IDLE ignores presses
    key_valid = 1'b1;
    key_data  = 4'd3;
    step();
    chk("idle press", {29'd0, move_ok, move_err, 1'b0}, 0);
    chk("idle board", 32'(board), 0);
    key_valid = 1'b0;
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    pulses = 0;
`ifdef TURN_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i < 16 && timeout) pulses++;
    end
    chk("to early", 32'(pulses), 0);
    chk("to pulse", 32'(timeout), 1);
    chk("to turn", 32'(is_turn_o), 1);
    chk("to board", 32'(board), 0);
    step();
    chk("to one cycle", 32'(timeout), 0);
`else
    repeat (40) begin
      step();
      if (timeout) pulses++;
    end
    chk("to off", 32'(pulses), 0);
    chk("to off turn", 32'(is_turn_o), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
